icache_ctrl: RTL and testbench

//  Direct-mapped instruction cache between ifetch and the memory controller.
//  - Hit: returns the 32-bit instruction word one cycle after the request.
//  - Miss: holds a refill request to the memory controller, writes the returned word, then answers ifetch.
//  - On a compressed refill whose upper halfword is also compressed, also fills the PC+2 entry.

---
 rtl/icache_ctrl_if.sv | 39 +++
 rtl/icache_ctrl.sv | 162 ++++++++++++++++
 tb/tb_icache_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : icache_ctrl_if
// Description : Fetch-side and refill-side handshake bundle of icache_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface icache_ctrl_if;
    logic        if2cache_en;
    logic [31:0] if2cache_PC;
    logic        cache2if_rdy;
    logic [31:0] cache2if_inst;
    logic [31:0] cache2if_PC;
    logic        cache_busy;
    logic        cache2mem_upd_en;
    logic [31:0] cache2mem_PC;
    logic        mem_busy;
    logic        mem2cache_upd;
    logic [31:0] mem2cache_PC;
    logic [31:0] mem2cache_inst;
    logic        is_c_inst;
    logic [31:0] sec_inst_addr;

    // Cache-side view.
    modport slave (
        input  if2cache_en, if2cache_PC, mem_busy, mem2cache_upd,
               mem2cache_PC, mem2cache_inst, is_c_inst, sec_inst_addr,
        output cache2if_rdy, cache2if_inst, cache2if_PC, cache_busy,
               cache2mem_upd_en, cache2mem_PC
    );

    // Environment view: ifetch plus memory controller.
    modport master (
        output if2cache_en, if2cache_PC, mem_busy, mem2cache_upd,
               mem2cache_PC, mem2cache_inst, is_c_inst, sec_inst_addr,
        input  cache2if_rdy, cache2if_inst, cache2if_PC, cache_busy,
               cache2mem_upd_en, cache2mem_PC
    );
endinterface
`default_nettype wire

// File: rtl/icache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icache_ctrl
// Description : Direct-mapped register-based instruction cache with
//               compressed second-halfword fill. Optional hit/miss counters
//               enabled by defining ICACHE_STAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_ctrl #(
    parameter int INDEX_WIDTH = 4,
    parameter int TAG_WIDTH   = 27
) (
    input  wire logic   clk_in,
    input  wire logic   rst_in,
    input  wire logic   rdy_in,
    input  wire logic   flush,
    icache_ctrl_if.slave bus
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int c_N = 1 << INDEX_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MISS = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic                   r_valid [c_N];
    logic [TAG_WIDTH-1:0]   r_tag   [c_N];
    logic [31:0]            r_data  [c_N];
    logic [1:0]             r_state;

    logic [INDEX_WIDTH-1:0] w_pri_idx, w_sec_idx, w_rd_idx;
    logic [TAG_WIDTH-1:0]   w_pri_tag, w_sec_tag, w_rd_tag;
    logic [31:0]            w_pri_data, w_sec_data;
    logic                   w_sec_en;
    logic                   w_lk_valid;
    logic [TAG_WIDTH-1:0]   w_lk_tag;
    logic [31:0]            w_lk_data;
    logic                   w_hit;
    logic                   w_unused;

    assign w_pri_idx  = bus.mem2cache_PC[INDEX_WIDTH:1];
    assign w_pri_tag  = bus.mem2cache_PC[31:INDEX_WIDTH+1];
    assign w_pri_data = bus.is_c_inst ? {16'b0, bus.mem2cache_inst[15:0]} : bus.mem2cache_inst;
    assign w_sec_idx  = bus.sec_inst_addr[INDEX_WIDTH:1];
    assign w_sec_tag  = bus.sec_inst_addr[31:INDEX_WIDTH+1];
    assign w_sec_data = {16'b0, bus.mem2cache_inst[31:16]};
    // On an index collision the secondary write is dropped so the primary wins.
    assign w_sec_en   = bus.mem2cache_upd && bus.is_c_inst
                     && (bus.mem2cache_inst[17:16] != 2'b11) && (w_sec_idx != w_pri_idx);

    assign w_rd_idx   = bus.if2cache_PC[INDEX_WIDTH:1];
    assign w_rd_tag   = bus.if2cache_PC[31:INDEX_WIDTH+1];

    // Lookup sees this cycle's fill writes (write-first).
    always_comb begin
        w_lk_valid = r_valid[w_rd_idx];
        w_lk_tag   = r_tag[w_rd_idx];
        w_lk_data  = r_data[w_rd_idx];
        if (w_sec_en && (w_sec_idx == w_rd_idx)) begin
            w_lk_valid = 1'b1;
            w_lk_tag   = w_sec_tag;
            w_lk_data  = w_sec_data;
        end
        if (bus.mem2cache_upd && (w_pri_idx == w_rd_idx)) begin
            w_lk_valid = 1'b1;
            w_lk_tag   = w_pri_tag;
            w_lk_data  = w_pri_data;
        end
    end

    assign w_hit    = w_lk_valid && (w_lk_tag == w_rd_tag);
    assign w_unused = ^{bus.mem_busy, bus.if2cache_PC[0], bus.mem2cache_PC[0], bus.sec_inst_addr[0]};

    // Fills are accepted in any state so a refill landing during a flush is kept.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < c_N; i++) r_valid[i] <= 1'b0;
        end else if (rdy_in && bus.mem2cache_upd) begin
            if (w_sec_en) begin
                r_valid[w_sec_idx] <= 1'b1;
                r_tag[w_sec_idx]   <= w_sec_tag;
                r_data[w_sec_idx]  <= w_sec_data;
            end
            r_valid[w_pri_idx] <= 1'b1;
            r_tag[w_pri_idx]   <= w_pri_tag;
            r_data[w_pri_idx]  <= w_pri_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state              <= S_IDLE;
            bus.cache2if_rdy     <= 1'b0;
            bus.cache2if_inst    <= 32'b0;
            bus.cache2if_PC      <= 32'b0;
            bus.cache_busy       <= 1'b0;
            bus.cache2mem_upd_en <= 1'b0;
            bus.cache2mem_PC     <= 32'b0;
`ifdef ICACHE_STAT_EN
            hit_cnt              <= 32'b0;
            miss_cnt             <= 32'b0;
`endif
        end else if (rdy_in) begin
            bus.cache2if_rdy <= 1'b0;
            if (flush) begin
                r_state              <= S_IDLE;
                bus.cache2if_inst    <= 32'b0;
                bus.cache2if_PC      <= 32'b0;
                bus.cache_busy       <= 1'b0;
                bus.cache2mem_upd_en <= 1'b0;
                bus.cache2mem_PC     <= 32'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.if2cache_en) begin
                            if (w_hit) begin
                                bus.cache2if_rdy  <= 1'b1;
                                bus.cache2if_inst <= w_lk_data;
                                bus.cache2if_PC   <= bus.if2cache_PC;
`ifdef ICACHE_STAT_EN
                                hit_cnt           <= hit_cnt + 32'd1;
`endif
                            end else begin
                                r_state              <= S_MISS;
                                bus.cache_busy       <= 1'b1;
                                bus.cache2mem_upd_en <= 1'b1;
                                bus.cache2mem_PC     <= bus.if2cache_PC;
`ifdef ICACHE_STAT_EN
                                miss_cnt             <= miss_cnt + 32'd1;
`endif
                            end
                        end
                    end
                    S_MISS: begin
                        if (bus.mem2cache_upd) begin
                            r_state              <= S_RESP;
                            bus.cache2mem_upd_en <= 1'b0;
                            bus.cache2if_inst    <= w_pri_data;
                            bus.cache2if_PC      <= bus.cache2mem_PC;
                        end
                    end
                    S_RESP: begin
                        r_state          <= S_IDLE;
                        bus.cache2if_rdy <= 1'b1;
                        bus.cache_busy   <= 1'b0;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    a_no_req_while_busy: assert property (@(posedge clk_in) disable iff (rst_in)
        !(rdy_in && !flush && bus.if2cache_en && bus.cache_busy));

endmodule
`default_nettype wire

// File: tb/tb_icache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_ctrl
// Description : Directed plus randomized bench for icache_ctrl against a
//               slot-by-address reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_ctrl;

    logic clk_in = 1'b0;
    logic rst_in, rdy_in, flush;
    icache_ctrl_if bus ();
`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    icache_ctrl #(.INDEX_WIDTH(4), .TAG_WIDTH(27)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .flush  (flush),
        .bus    (bus)
`ifdef ICACHE_STAT_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;
    int n_hit = 0;
    int n_miss = 0;

    // Reference: each of 16 slots remembers which address it holds and the word.
    logic        m_valid [16];
    logic [31:0] m_addr  [16];
    logic [31:0] m_data  [16];

    function automatic int slot_of(input logic [31:0] pc);
        return int'((pc / 2) % 16);
    endfunction

    function automatic logic is_c(input logic [31:0] w);
        return (w % 4) != 3;
    endfunction

    function automatic logic [31:0] resp_word(input logic [31:0] w);
        return is_c(w) ? (w % 32'h10000) : w;
    endfunction

    function automatic logic m_hit(input logic [31:0] pc);
        int s = slot_of(pc);
        return m_valid[s] && ((m_addr[s] / 32) == (pc / 32));
    endfunction

    task automatic model_fill(input logic [31:0] pc, input logic [31:0] w);
        int s  = slot_of(pc);
        int s2 = slot_of(pc + 2);
        m_valid[s] = 1'b1; m_addr[s] = pc; m_data[s] = resp_word(w);
        if (is_c(w) && (((w / 32'h10000) % 4) != 3) && s2 != s) begin
            m_valid[s2] = 1'b1; m_addr[s2] = pc + 2; m_data[s2] = w / 32'h10000;
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_refill(input logic [31:0] pc, input logic [31:0] w);
        bus.mem2cache_upd  = 1'b1;
        bus.mem2cache_PC   = pc;
        bus.mem2cache_inst = w;
        bus.is_c_inst      = is_c(w);
        bus.sec_inst_addr  = is_c(w) ? pc + 2 : 32'h0;
    endtask

    task automatic clear_refill();
        bus.mem2cache_upd = 1'b0; bus.mem2cache_PC = 32'h0; bus.mem2cache_inst = 32'h0;
        bus.is_c_inst = 1'b0; bus.sec_inst_addr = 32'h0;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] w, input int lat);
        logic        hit;
        logic [31:0] exp;
        hit = m_hit(pc);
        exp = m_data[slot_of(pc)];
        bus.if2cache_en = 1'b1; bus.if2cache_PC = pc;
        tick();
        bus.if2cache_en = 1'b0;
        if (hit) begin
            n_hit++;
            chk("hit_rdy", {31'b0, bus.cache2if_rdy}, 32'd1);
            chk("hit_inst", bus.cache2if_inst, exp);
            chk("hit_pc", bus.cache2if_PC, pc);
            chk("hit_no_upd", {31'b0, bus.cache2mem_upd_en}, 32'd0);
        end else begin
            n_miss++;
            chk("miss_upd_en", {31'b0, bus.cache2mem_upd_en}, 32'd1);
            chk("miss_mem_pc", bus.cache2mem_PC, pc);
            chk("miss_busy", {31'b0, bus.cache_busy}, 32'd1);
            chk("miss_no_rdy", {31'b0, bus.cache2if_rdy}, 32'd0);
            repeat (lat) begin
                bus.mem_busy = 1'($urandom_range(0, 1));
                tick();
                chk("hold_upd_en", {31'b0, bus.cache2mem_upd_en}, 32'd1);
                chk("hold_mem_pc", bus.cache2mem_PC, pc);
            end
            bus.mem_busy = 1'b0;
            drive_refill(pc, w);
            tick();
            clear_refill();
            model_fill(pc, w);
            chk("fill_drop_upd", {31'b0, bus.cache2mem_upd_en}, 32'd0);
            chk("fill_no_rdy_yet", {31'b0, bus.cache2if_rdy}, 32'd0);
            tick();
            chk("resp_rdy", {31'b0, bus.cache2if_rdy}, 32'd1);
            chk("resp_inst", bus.cache2if_inst, resp_word(w));
            chk("resp_pc", bus.cache2if_PC, pc);
            chk("resp_busy_low", {31'b0, bus.cache_busy}, 32'd0);
        end
        tick();
        chk("rdy_pulse_end", {31'b0, bus.cache2if_rdy}, 32'd0);
    endtask

    initial begin
        logic [31:0] pc, w;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_addr[i] = 32'h0; m_data[i] = 32'h0;
        end
        rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
        bus.if2cache_en = 1'b0; bus.if2cache_PC = 32'h0; bus.mem_busy = 1'b0;
        clear_refill();
        repeat (3) tick();
        rst_in = 1'b0;
        tick();
        chk("rst_rdy", {31'b0, bus.cache2if_rdy}, 32'd0);
        chk("rst_upd_en", {31'b0, bus.cache2mem_upd_en}, 32'd0);
        chk("rst_busy", {31'b0, bus.cache_busy}, 32'd0);
        chk("rst_inst", bus.cache2if_inst, 32'h0);

        // Basic miss then hit, eviction, compressed pair, non-compressed.
        fetch(32'h0000_0000, 32'h0000_0513, 2);
        fetch(32'h0000_0000, 32'h0000_0513, 0);
        fetch(32'h0000_0020, 32'h0200_0093, 1);
        fetch(32'h0000_0000, 32'h0000_0513, 1);
        fetch(32'h0000_0100, 32'h4501_4501, 1);
        fetch(32'h0000_0102, 32'h0000_0000, 0);
        chk("c_pair_model_hit", {31'b0, m_hit(32'h102)}, 32'd1);
        fetch(32'h0000_0200, 32'h00A5_0513, 0);
        fetch(32'h0000_0202, 32'h1234_5677, 0);
`ifdef ICACHE_STAT_EN
        chk("stat_hit_early", hit_cnt, n_hit);
        chk("stat_miss_early", miss_cnt, n_miss);
`endif

        // Flush while the memory is busy drops the request and the response.
        bus.if2cache_en = 1'b1; bus.if2cache_PC = 32'h40;
        tick();
        bus.if2cache_en = 1'b0; n_miss++;
        chk("fl_upd_en", {31'b0, bus.cache2mem_upd_en}, 32'd1);
        bus.mem_busy = 1'b1;
        repeat (5) begin
            tick();
            chk("fl_hold_upd", {31'b0, bus.cache2mem_upd_en}, 32'd1);
            chk("fl_hold_pc", bus.cache2mem_PC, 32'h40);
        end
        bus.mem_busy = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_upd_drop", {31'b0, bus.cache2mem_upd_en}, 32'd0);
        chk("fl_busy_drop", {31'b0, bus.cache_busy}, 32'd0);
        chk("fl_no_rdy", {31'b0, bus.cache2if_rdy}, 32'd0);
        repeat (2) begin
            tick();
            chk("fl_no_rdy_late", {31'b0, bus.cache2if_rdy}, 32'd0);
        end
        chk("fl_not_filled", {31'b0, m_hit(32'h40)}, 32'd0);
        fetch(32'h0000_0040, 32'h0000_0297, 0);

        // Refill landing in the flush cycle is still written.
        bus.if2cache_en = 1'b1; bus.if2cache_PC = 32'h60;
        tick();
        bus.if2cache_en = 1'b0; n_miss++;
        flush = 1'b1;
        drive_refill(32'h60, 32'h0000_0001);
        tick();
        flush = 1'b0;
        clear_refill();
        model_fill(32'h60, 32'h0000_0001);
        chk("flw_no_rdy", {31'b0, bus.cache2if_rdy}, 32'd0);
        chk("flw_upd_drop", {31'b0, bus.cache2mem_upd_en}, 32'd0);
        tick();
        chk("flw_no_rdy_late", {31'b0, bus.cache2if_rdy}, 32'd0);
        fetch(32'h0000_0060, 32'h0, 0);
        fetch(32'h0000_0062, 32'h0, 0);

        // Freeze: a hit request under rdy_in=0 produces nothing until released.
        rdy_in = 1'b0; bus.if2cache_en = 1'b1; bus.if2cache_PC = 32'h60;
        repeat (3) begin
            tick();
            chk("frz_no_rdy", {31'b0, bus.cache2if_rdy}, 32'd0);
        end
        rdy_in = 1'b1;
        tick();
        bus.if2cache_en = 1'b0; n_hit++;
        chk("frz_rdy", {31'b0, bus.cache2if_rdy}, 32'd1);
        chk("frz_inst", bus.cache2if_inst, 32'h0000_0001);
        tick();

        // Flush beats a simultaneous request.
        flush = 1'b1; bus.if2cache_en = 1'b1; bus.if2cache_PC = 32'h60;
        tick();
        flush = 1'b0; bus.if2cache_en = 1'b0;
        chk("fl_en_dropped", {31'b0, bus.cache2if_rdy}, 32'd0);

        // Lookup and fill of the same slot in one cycle: the new word is returned.
        bus.if2cache_en = 1'b1; bus.if2cache_PC = 32'h1E0;
        drive_refill(32'h1E0, 32'h00C5_8593);
        model_fill(32'h1E0, 32'h00C5_8593);
        tick();
        bus.if2cache_en = 1'b0; clear_refill(); n_hit++;
        chk("byp_rdy", {31'b0, bus.cache2if_rdy}, 32'd1);
        chk("byp_inst", bus.cache2if_inst, 32'h00C5_8593);
        chk("byp_no_upd", {31'b0, bus.cache2mem_upd_en}, 32'd0);
        tick();

        // Random traffic over two tags to mix hits, misses and pair fills.
        for (int k = 0; k < 60; k++) begin
            pc = ($urandom_range(0, 1) * 32) + ($urandom_range(0, 15) * 2) + 32'h400;
            w  = $urandom;
            if ($urandom_range(0, 1) == 0) w = w | 32'h3;
            fetch(pc, w, int'($urandom_range(0, 3)));
        end

`ifdef ICACHE_STAT_EN
        chk("stat_hit_final", hit_cnt, n_hit);
        chk("stat_miss_final", miss_cnt, n_miss);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
